// File: rtl/ysyx_040750_csr_regfile.sv
// ============================================================================
// Module   : ysyx_040750_csr_regfile
// Brief    : RV64 machine-mode CSR register file with trap/mret state updates
//            and a free-running mcycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_040750_csr_regfile #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000000a00001800
) (
    input  logic            I_sys_clk,
    input  logic            I_rst_n,
    input  logic [11:0]     I_raddr,
    output logic [XLEN-1:0] O_rdata,
    output logic            O_rillegal,
    input  logic            I_wen,
    input  logic [11:0]     I_waddr,
    input  logic [XLEN-1:0] I_wdata,
    input  logic            I_trap,
    input  logic [XLEN-1:0] I_trap_pc,
    input  logic [XLEN-1:0] I_trap_cause,
    input  logic            I_mret,
    output logic [XLEN-1:0] O_trap_vec,
    output logic [XLEN-1:0] O_mret_pc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

    // Only MIE/MPIE of mstatus carry state; the rest is rebuilt from the reset image.
    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mcycle_q,   mcycle_d;
    logic [XLEN-1:0] mstatus_val;

    always_comb begin
        mstatus_val        = MSTATUS_RST;
        mstatus_val[3]     = mstatus_mie_q;
        mstatus_val[7]     = mstatus_mpie_q;
        mstatus_val[12:11] = 2'b11;
    end

    always_comb begin
        O_rdata    = '0;
        O_rillegal = 1'b0;
        case (I_raddr)
            ADDR_MSTATUS:  O_rdata = mstatus_val;
            ADDR_MIE:      O_rdata = mie_q;
            ADDR_MTVEC:    O_rdata = mtvec_q;
            ADDR_MSCRATCH: O_rdata = mscratch_q;
            ADDR_MEPC:     O_rdata = mepc_q;
            ADDR_MCAUSE:   O_rdata = mcause_q;
            ADDR_MIP:      O_rdata = '0;
            ADDR_MCYCLE:   O_rdata = mcycle_q;
            default:       O_rillegal = 1'b1;
        endcase
    end

    assign O_trap_vec = {mtvec_q[XLEN-1:2], 2'b00};
    assign O_mret_pc  = mepc_q;

    // CSR writes are applied first; trap/mret then overwrite the fields they own.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 1'b1;

        if (I_wen) begin
            case (I_waddr)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = I_wdata[3];
                    mstatus_mpie_d = I_wdata[7];
                end
                ADDR_MIE:      mie_d      = I_wdata;
                ADDR_MTVEC:    mtvec_d    = {I_wdata[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_d = I_wdata;
                ADDR_MEPC:     mepc_d     = {I_wdata[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_d   = I_wdata;
                ADDR_MCYCLE:   mcycle_d   = I_wdata;
                default:       ;
            endcase
        end

        if (I_trap) begin
            mepc_d         = {I_trap_pc[XLEN-1:2], 2'b00};
            mcause_d       = I_trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (I_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mstatus_mie_q  <= MSTATUS_RST[3];
            mstatus_mpie_q <= MSTATUS_RST[7];
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_040750_csr_regfile.sv
// ============================================================================
// Module   : tb_ysyx_040750_csr_regfile
// Brief    : Directed self-checking bench for the machine-mode CSR file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_040750_csr_regfile;

    logic        clk;
    logic        rst_n;
    logic [11:0] raddr;
    logic [63:0] rdata;
    logic        rillegal;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        trap;
    logic [63:0] trap_pc;
    logic [63:0] trap_cause;
    logic        mret;
    logic [63:0] trap_vec;
    logic [63:0] mret_pc;

    int n_vec  = 0;
    int n_fail = 0;

    ysyx_040750_csr_regfile dut (
        .I_sys_clk   (clk),
        .I_rst_n     (rst_n),
        .I_raddr     (raddr),
        .O_rdata     (rdata),
        .O_rillegal  (rillegal),
        .I_wen       (wen),
        .I_waddr     (waddr),
        .I_wdata     (wdata),
        .I_trap      (trap),
        .I_trap_pc   (trap_pc),
        .I_trap_cause(trap_cause),
        .I_mret      (mret),
        .O_trap_vec  (trap_vec),
        .O_mret_pc   (mret_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read a CSR combinationally and compare.
    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
        raddr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    // Advance one rising edge, then clear single-cycle strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        wen  = 1'b0;
        trap = 1'b0;
        mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; raddr = 12'h300; wen = 1'b0; waddr = '0; wdata = '0;
        trap = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rd("rst_mstatus", 12'h300, 64'ha00001800);
        check("rst_trap_vec", trap_vec, 64'h0);
        check("rst_mret_pc", mret_pc, 64'h0);
        rst_n = 1'b1;
        rd("mcycle0", 12'hB00, 64'd0);
        tick();
        rd("mcycle1", 12'hB00, 64'd1);
        tick();
        rd("mcycle2", 12'hB00, 64'd2);

        // mtvec write, low bits masked, no bypass
        wen = 1'b1; waddr = 12'h305; wdata = 64'h8000_0103;
        rd("mtvec_nobypass", 12'h305, 64'h0);
        tick();
        rd("mtvec_rd", 12'h305, 64'h8000_0100);
        check("trap_vec", trap_vec, 64'h8000_0100);

        // mstatus write masks
        wen = 1'b1; waddr = 12'h300; wdata = '1;
        tick();
        rd("mstatus_ones", 12'h300, 64'ha00001888);
        wen = 1'b1; waddr = 12'h300; wdata = 64'h8;
        tick();
        rd("mstatus_mie", 12'h300, 64'ha00001808);

        // mip read-only
        wen = 1'b1; waddr = 12'h344; wdata = '1;
        tick();
        rd("mip_rd", 12'h344, 64'h0);
        check("mip_legal", {63'b0, rillegal}, 64'h0);

        // trap entry
        trap = 1'b1; trap_pc = 64'h8000_0013; trap_cause = 64'd11;
        tick();
        rd("trap_mepc", 12'h341, 64'h8000_0010);
        rd("trap_mcause", 12'h342, 64'd11);
        rd("trap_mstatus", 12'h300, 64'ha00001880);
        check("trap_mret_pc", mret_pc, 64'h8000_0010);

        // mret, concurrent mstatus write dropped
        mret = 1'b1; wen = 1'b1; waddr = 12'h300; wdata = 64'h0;
        tick();
        rd("mret_mstatus", 12'h300, 64'ha00001888);
        check("mret_pc", mret_pc, 64'h8000_0010);

        // trap + mret + mepc write: trap wins
        trap = 1'b1; mret = 1'b1; trap_pc = 64'h8000_0020; trap_cause = 64'd11;
        wen = 1'b1; waddr = 12'h341; wdata = 64'd5;
        tick();
        rd("prio_mepc", 12'h341, 64'h8000_0020);
        rd("prio_mstatus", 12'h300, 64'ha00001880);

        // trap with unrelated CSR write still commits
        trap = 1'b1; trap_pc = 64'h8000_0040; trap_cause = 64'd3;
        wen = 1'b1; waddr = 12'h340; wdata = 64'hdead_beef_0000_1234;
        tick();
        rd("trap_mscratch", 12'h340, 64'hdead_beef_0000_1234);
        rd("trap2_mcause", 12'h342, 64'd3);
        rd("trap2_mstatus", 12'h300, 64'ha00001800);

        // mcycle write and wrap
        wen = 1'b1; waddr = 12'hB00; wdata = '1;
        tick();
        rd("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mcycle_wrap", 12'hB00, 64'h0);

        // unimplemented address
        rd("illegal_rdata", 12'h7C0, 64'h0);
        check("illegal_flag", {63'b0, rillegal}, 64'h1);

        // asynchronous reset mid-operation, pending trap lost
        trap = 1'b1; trap_pc = 64'h9000_0000; trap_cause = 64'd11;
        #2;
        rst_n = 1'b0;
        #1;
        trap = 1'b0;
        rd("arst_mstatus", 12'h300, 64'ha00001800);
        check("arst_trap_vec", trap_vec, 64'h0);
        check("arst_mret_pc", mret_pc, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd("arst_mcycle0", 12'hB00, 64'd0);
        rd("arst_mscratch", 12'h340, 64'h0);
        tick();
        rd("arst_mcycle1", 12'hB00, 64'd1);
        rd("arst_mepc", 12'h341, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
